jk_latch_driver: RTL and testbench
==================================

# jk_latch_driver

Sequencing stage that sits directly upstream of the level-sensitive JK latch and drives its J, K and En inputs from a queued stream of clocked commands. Every enable pulse is framed with programmable setup and hold windows so that J/K never change while the latch is transparent. The block tracks the latch's expected state, so toggle commands are resolved into explicit set or reset. The latch therefore never sees J=K=1 with En high and cannot oscillate.

## Interface
Parameters:
- SETUP_CYC, default 1: cycles J/K are stable before En rises; legal range 1..15.
- PULSE_CYC, default 1: cycles En is held high; legal range 1..15.
- HOLD_CYC, default 1: cycles J/K are held after En falls; legal range 1..15.
- FIFO_DEPTH, default 4: command queue depth; must be a power of two, at least 2.

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- cmd_valid, input, 1: a command is offered.
- cmd_ready, output, 1: the queue can accept a command.
- cmd_op, input, 2: {J,K} command: 00 hold, 01 reset, 10 set, 11 toggle.
- J, output, 1: latch J input, registered.
- K, output, 1: latch K input, registered.
- En, output, 1: latch enable, registered.
- q_model, output, 1: expected latch Q.
- busy, output, 1: the FSM is not IDLE, or the queue is not empty.
- op_done, output, 1: one-cycle pulse on the last HOLD cycle of a driven op.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current queue occupancy.

## Operation
- **Reset.** J=K=En=0, q_model=0, op_done=0, busy=0, fifo_count=0, cmd_ready=1. The FSM enters IDLE and the queue is flushed.
- **Queue.** A command is pushed when cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count != FIFO_DEPTH), decoded from registered count.
  - There is no bypass: a pushed entry is poppable the following cycle.
- **FSM states:** IDLE, SETUP, PULSE, HOLD. All outputs are registered.
- **IDLE, queue empty:** J=K=En=0.
- **IDLE, queue non-empty:** pop the head entry and resolve it:
  - 00 is consumed in place: no drive, state stays IDLE, q_model unchanged.
  - 01 → {J,K}=01.
  - 10 → {J,K}=10.
  - 11 → {J,K}=10 if q_model=0, otherwise 01. J=K=1 is never driven.
  - For any driving op: load the resolved J/K, go to SETUP, counter=SETUP_CYC-1.
- **SETUP:** En=0. When the counter reaches 0 → PULSE, En←1, counter=PULSE_CYC-1.
- **PULSE:** En=1. When the counter reaches 0 → HOLD, En←0, counter=HOLD_CYC-1, q_model←J.
- **HOLD:** En=0, J/K held. When the counter reaches 0 → IDLE, J=K←0, op_done high on this last HOLD cycle.
- **Queue status during a drive:** pushes continue and fifo_count is exact while the FSM is busy.
- **Simultaneous push and pop:** count is unchanged and the data is ordered correctly.
- **Push while full:** ignored; cmd_ready is already low.
- **Reset mid-op:** En drops asynchronously and all state returns to reset values. q_model may then disagree with the physical latch; the system is responsible for a re-init set or reset.

## Timing
- Push at edge t; earliest pop at t+1; J/K valid from t+2; En high from t+2+SETUP_CYC.
- A driven op occupies 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles, counted from its pop cycle through its last HOLD cycle. With defaults that is 4 cycles per op; back-to-back driven ops repeat every 4 cycles.
- A hold op (00) costs 1 cycle.
- J/K are constant from 1 cycle before En rises until HOLD_CYC cycles after En falls.
- q_model updates on the same edge that En falls.

## Structure
- Package jk_pkg holds:
  - the op localparams OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TGL=2'b11;
  - the FSM state encoding;
  - a 4-bit counter width constant.
- Sub-module jk_cmd_fifo: a synchronous FIFO with async active-low reset, FIFO_DEPTH entries, 2-bit data, push/pop, full/empty and count.
- The top level holds the FSM, the counter, toggle resolution and q_model.

## Test plan
- **Reset mid-PULSE:** assert rst_n low while En=1 → En, J, K, q_model and fifo_count are 0 immediately (asynchronously); cmd_ready=1.
- **Basic set:** single op 10 with defaults, pushed at cycle 0 → J=1 from cycle 2, En=1 only in cycle 3, q_model=1 from cycle 4, op_done in cycle 4, J=0 from cycle 5.
- **Toggle resolution:** ops 11, 11, 11 from reset → drives {J,K}=10, 01, 10; q_model ends at 1; J&&K is never high.
- **Full queue:** push 6 ops back-to-back at FIFO_DEPTH=4 → cmd_ready falls after the fourth accepted op is queued; no op is lost or duplicated; execution order matches push order.
- **Timing parameters:** SETUP_CYC=3, PULSE_CYC=2, HOLD_CYC=2 with op 01 → J/K are stable 3 cycles before En rises, En is high exactly 2 cycles, J/K are held 2 cycles after En falls.
- **Hold op mix:** ops 00, 10, 00 → the 00 ops produce no En activity, each costs 1 cycle, and q_model is unaffected by them.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared op codes, FSM encoding and helpers for the JK latch driver.
package jk_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_HOLD = 2'b00;
  localparam logic [OP_W-1:0] OP_RST  = 2'b01;
  localparam logic [OP_W-1:0] OP_SET  = 2'b10;
  localparam logic [OP_W-1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  // Toggle becomes an explicit set or reset so J=K=1 is never driven.
  function automatic jk_drive_t resolve_op(input logic [OP_W-1:0] op, input logic q);
    jk_drive_t d;
    d = '{j: op[1], k: op[0]};
    if (op == OP_TGL) d = '{j: ~q, k: q};
    return d;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count; no bypass path.
module jk_cmd_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_pop,
  output logic [DATA_W-1:0]         o_data_c,
  output logic                      o_full_c,
  output logic                      o_empty_c,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full_c  = (r_count == FCNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_data_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jk_latch_driver.sv
// Drives J/K/En of a level-sensitive JK latch from queued commands with
// setup/pulse/hold framing and a tracked model of the latch state.
module jk_latch_driver
  import jk_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned PULSE_CYC  = 1,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  output logic                          J,
  output logic                          K,
  output logic                          En,
  output logic                          q_model,
  output logic                          busy,
  output logic                          op_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_j, r_k, r_en, r_q, r_done;
  logic              w_j_nxt, w_k_nxt, w_en_nxt, w_q_nxt, w_done_nxt;
  logic              w_pop;
  logic [OP_W-1:0]   w_head_c;
  logic              w_full_c, w_empty_c;
  jk_drive_t         w_drv;

  jk_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (OP_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (cmd_valid),
    .i_data    (cmd_op),
    .i_pop     (w_pop),
    .o_data_c  (w_head_c),
    .o_full_c  (w_full_c),
    .o_empty_c (w_empty_c),
    .o_count   (fifo_count)
  );

  assign w_drv     = resolve_op(w_head_c, r_q);
  assign cmd_ready = !w_full_c;
  assign busy      = (r_state != ST_IDLE) || !w_empty_c;
  assign J         = r_j;
  assign K         = r_k;
  assign En        = r_en;
  assign q_model   = r_q;
  assign op_done   = r_done;

  // State register and registered latch-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_en    <= 1'b0;
      r_q     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_en    <= w_en_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_en_nxt    = r_en;
    w_q_nxt     = r_q;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Hold ops are consumed here without framing a pulse.
        if (!w_empty_c) begin
          w_pop = 1'b1;
          if (w_head_c != OP_HOLD) begin
            w_j_nxt     = w_drv.j;
            w_k_nxt     = w_drv.k;
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          end
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_PULSE;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = CNT_W'(PULSE_CYC - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_en_nxt    = 1'b0;
          w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
          w_q_nxt     = r_j;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_j_nxt     = 1'b0;
          w_k_nxt     = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Registered pulse lands on the final HOLD cycle.
    w_done_nxt = (w_state_nxt == ST_HOLD) && (w_cnt_nxt == '0);
  end

endmodule

// File: tb/tb_jk_latch_driver.sv
// Bench for jk_latch_driver: two instances (default and 3/2/2 timing) checked
// every cycle against a timeline model, plus hand-computed expectations.
module tb_jk_latch_driver;

  localparam int unsigned D  = 4;
  localparam int unsigned SB = 3;
  localparam int unsigned PB = 2;
  localparam int unsigned HB = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_vld, b_vld;
  logic [1:0] a_op, b_op;
  logic       a_rdy, a_j, a_k, a_en, a_q, a_busy, a_done;
  logic       b_rdy, b_j, b_k, b_en, b_q, b_busy, b_done;
  logic [2:0] a_cnt, b_cnt;

  always #5 clk = ~clk;

  jk_latch_driver u_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_vld), .cmd_ready(a_rdy), .cmd_op(a_op),
    .J(a_j), .K(a_k), .En(a_en), .q_model(a_q), .busy(a_busy), .op_done(a_done),
    .fifo_count(a_cnt)
  );

  jk_latch_driver #(.SETUP_CYC(SB), .PULSE_CYC(PB), .HOLD_CYC(HB), .FIFO_DEPTH(D)) u_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_vld), .cmd_ready(b_rdy), .cmd_op(b_op),
    .J(b_j), .K(b_k), .En(b_en), .q_model(b_q), .busy(b_busy), .op_done(b_done),
    .fifo_count(b_cnt)
  );

  int         n_vec = 0;
  int         n_err = 0;
  // Model: offset within the current op (-1 idle), resolved drive, latch state, queue.
  int         me [2] = '{-1, -1};
  bit         mj [2], mk [2], mq [2];
  logic [1:0] mbuf [2][16];
  int         mn [2] = '{0, 0};
  logic [1:0] seen [$];
  int         en_cycles = 0;
  bit         saw_full;

  function automatic int ps(input int d); return (d == 0) ? 1 : int'(SB); endfunction
  function automatic int pp(input int d); return (d == 0) ? 1 : int'(PB); endfunction
  function automatic int plen(input int d);
    return (d == 0) ? 4 : 1 + int'(SB) + int'(PB) + int'(HB);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_adv();
    logic       v;
    logic [1:0] op, h;
    bit         push_ok;
    for (int d = 0; d < 2; d++) begin
      v  = (d == 0) ? a_vld : b_vld;
      op = (d == 0) ? a_op : b_op;
      if (!rst_n) begin
        me[d] = -1; mq[d] = 0; mj[d] = 0; mk[d] = 0; mn[d] = 0;
        continue;
      end
      push_ok = v && (mn[d] != int'(D));
      if (me[d] >= 0) begin
        me[d]++;
        if (me[d] == 1 + ps(d) + pp(d)) mq[d] = mj[d];
        if (me[d] == plen(d)) me[d] = -1;
      end else if (mn[d] > 0) begin
        h = mbuf[d][0];
        for (int i = 0; i < 15; i++) mbuf[d][i] = mbuf[d][i+1];
        mn[d]--;
        if (h != 2'b00) begin
          if (h == 2'b11) begin mj[d] = !mq[d]; mk[d] = mq[d]; end
          else begin mj[d] = h[1]; mk[d] = h[0]; end
          me[d] = 1;
        end
      end
      if (push_ok) begin
        mbuf[d][mn[d]] = op;
        mn[d]++;
      end
    end
  endtask

  task automatic half();
    logic [9:0] act, exp;
    bit         on;
    string      nm;
    @(negedge clk);
    if (a_en) begin seen.push_back({a_j, a_k}); en_cycles++; end
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        on  = (me[d] >= 0);
        exp = {mn[d] != int'(D), on & mj[d], on & mk[d],
               on && me[d] >= 1 + ps(d) && me[d] <= ps(d) + pp(d),
               mq[d], on || mn[d] != 0, on && me[d] == plen(d) - 1, 3'(mn[d])};
        act = (d == 0) ? {a_rdy, a_j, a_k, a_en, a_q, a_busy, a_done, a_cnt}
                       : {b_rdy, b_j, b_k, b_en, b_q, b_busy, b_done, b_cnt};
        nm  = (d == 0) ? "a_outputs" : "b_outputs";
        check(nm, 32'(act), 32'(exp));
      end
      check("a_jk_both_high", 32'(a_j & a_k), 32'(0));
      check("b_jk_both_high", 32'(b_j & b_k), 32'(0));
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic tick(); half(); edge_(); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_a(input logic [1:0] op);
    bit took = 0;
    a_vld = 1'b1;
    a_op  = op;
    for (int i = 0; i < 50 && !took; i++) begin
      took = a_rdy;
      if (!a_rdy) saw_full = 1;
      tick();
    end
    a_vld = 1'b0;
    check("a_push_accept", 32'(took), 32'(1));
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      tick();
      idle = !a_busy && !b_busy;
    end
    check("idle_wait", 32'(idle), 32'(1));
  endtask

  function automatic logic [3:0] exp_a(input int c);
    case (c)
      0, 1:    return 4'b0000;
      2:       return 4'b1000;
      3:       return 4'b1100;
      4:       return 4'b1011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [2:0] exp_b(input int c);
    case (c)
      2, 3, 4, 7: return 3'b100;
      5, 6:       return 3'b110;
      8:          return 3'b101;
      default:    return 3'b000;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a_vld = 0; b_vld = 0; a_op = 0; b_op = 0; saw_full = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("a_reset_state", 32'({a_rdy, a_j, a_k, a_en, a_q, a_busy, a_done, a_cnt}), 32'(10'b1000000000));
    check("b_reset_state", 32'({b_rdy, b_j, b_k, b_en, b_q, b_busy, b_done, b_cnt}), 32'(10'b1000000000));
    edge_();
    tick();
    rst_n = 1'b1;

    // Basic set on A and 3/2/2-framed reset on B, pushed together in cycle 0.
    a_vld = 1; a_op = 2'b10; b_vld = 1; b_op = 2'b01;
    for (int c = 0; c <= 10; c++) begin
      half();
      check("a_set_timing", 32'({a_j, a_en, a_q, a_done}), 32'(exp_a(c)));
      check("b_frame_timing", 32'({b_k, b_en, b_done}), 32'(exp_b(c)));
      edge_();
      a_vld = 0; b_vld = 0;
    end
    wait_idle();

    // Three toggles from reset resolve to set, reset, set.
    do_reset();
    seen.delete();
    push_a(2'b11); push_a(2'b11); push_a(2'b11);
    wait_idle();
    check("tgl_count", 32'(seen.size()), 32'(3));
    if (seen.size() == 3) begin
      check("tgl_drive0", 32'(seen[0]), 32'(2'b10));
      check("tgl_drive1", 32'(seen[1]), 32'(2'b01));
      check("tgl_drive2", 32'(seen[2]), 32'(2'b10));
    end
    check("tgl_q_final", 32'(a_q), 32'(1));

    // Six ops back-to-back overflow the 4-deep queue; handshake keeps them all.
    do_reset();
    seen.delete();
    saw_full = 0;
    push_a(2'b10); push_a(2'b01); push_a(2'b11);
    push_a(2'b00); push_a(2'b10); push_a(2'b11);
    wait_idle();
    check("full_seen_not_ready", 32'(saw_full), 32'(1));
    check("full_drive_count", 32'(seen.size()), 32'(5));
    if (seen.size() == 5) begin
      check("full_order0", 32'(seen[0]), 32'(2'b10));
      check("full_order1", 32'(seen[1]), 32'(2'b01));
      check("full_order2", 32'(seen[2]), 32'(2'b10));
      check("full_order3", 32'(seen[3]), 32'(2'b10));
      check("full_order4", 32'(seen[4]), 32'(2'b01));
    end
    check("full_q_final", 32'(a_q), 32'(0));

    // Hold ops around a set: only one enable pulse, q follows the set alone.
    do_reset();
    en_cycles = 0;
    push_a(2'b00); push_a(2'b10); push_a(2'b00);
    wait_idle();
    check("hold_mix_en_cycles", 32'(en_cycles), 32'(1));
    check("hold_mix_q", 32'(a_q), 32'(1));

    // Asynchronous reset while En is high, with a second op still queued.
    push_a(2'b01); push_a(2'b10);
    begin
      bit hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
        half();
        hit = a_en;
        if (!hit) edge_();
      end
      check("midpulse_en_seen", 32'(hit), 32'(1));
    end
    #1 rst_n = 1'b0;
    #1;
    check("midpulse_reset_outs", 32'({a_en, a_j, a_k, a_q, a_done, a_cnt}), 32'(0));
    check("midpulse_reset_ready", 32'(a_rdy), 32'(1));
    edge_();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
